fifo_fm0_tx_encoder: RTL and testbench

Downstream consumer of the single-clock tag FIFO. It pops bytes through the FIFO controller's read handshake and serialises them MSB-first as an FM0 backscatter waveform. Each frame is a fixed preamble, then the payload bytes, then a dummy-1 end-of-signalling bit. The output drives the tag modulator.

---
 rtl/fifo_fm0_tx_encoder.sv | 206 ++++++++++++++++++++
 tb/tb_fifo_fm0_tx_encoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_fm0_tx_encoder.sv
// FM0 backscatter transmitter fed from the single-clock tag FIFO.
// A frame is a 12 half-bit preamble, the payload bytes MSB first, and a
// dummy-1 end-of-signalling bit. The next byte is prefetched during bit 0
// of the current byte so consecutive bytes go out without a gap.
module fifo_fm0_tx_encoder #(
    parameter int HALF_PERIOD = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read_en,
    output logic       tx_out,
    output logic       busy,
    output logic       done
);

    // Half-bit counter just wide enough to reach HALF_PERIOD-1.
    localparam int              HW            = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [HW-1:0]   HALF_LAST     = HW'(HALF_PERIOD - 1);
    // Preamble levels, transmitted from bit 11 down to bit 0.
    localparam logic [11:0]     PREAMBLE_BITS = 12'b110100100011;
    localparam logic [3:0]      PREAMBLE_LAST = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DUMMY
    } state_t;

    state_t          state_reg, state_next;
    logic [HW-1:0]   half_cnt_reg, half_cnt_next;
    logic [3:0]      sym_idx_reg, sym_idx_next;      // preamble half-bit index
    logic [2:0]      bit_idx_reg, bit_idx_next;      // payload bit, 7 down to 0
    logic            phase_reg, phase_next;          // 0 = first half of a bit
    logic [7:0]      data_reg, data_next;            // byte being transmitted
    logic [7:0]      next_byte_reg, next_byte_next;  // prefetched byte
    logic            have_next_reg, have_next_next;
    logic            read_en_reg, read_en_next;
    logic            tx_reg, tx_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;

    logic            half_end;
    logic            cur_bit;
    logic            prefetch_slot;

    assign half_end      = (half_cnt_reg == HALF_LAST);
    assign cur_bit       = data_reg[bit_idx_reg];
    // First cycle of bit 0: the only point where the next byte is requested.
    assign prefetch_slot = (state_reg == DATA) && (bit_idx_reg == 3'd0) &&
                           !phase_reg && (half_cnt_reg == '0);

    // Next-state and datapath: levels only change on half-bit boundaries.
    always_comb begin
        state_next     = state_reg;
        half_cnt_next  = half_cnt_reg;
        sym_idx_next   = sym_idx_reg;
        bit_idx_next   = bit_idx_reg;
        phase_next     = phase_reg;
        data_next      = data_reg;
        next_byte_next = next_byte_reg;
        have_next_next = have_next_reg;
        read_en_next   = 1'b0;
        tx_next        = tx_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;

        // Free-running half-bit timer while a frame is in flight.
        if (state_reg == IDLE || half_end) begin
            half_cnt_next = '0;
        end else begin
            half_cnt_next = half_cnt_reg + HW'(1);
        end

        // FIFO read data is captured on the edge after a pop was issued.
        if (read_en_reg) begin
            if (state_reg == PREAMBLE) begin
                data_next = fifo_data;
            end else if (state_reg == DATA) begin
                next_byte_next = fifo_data;
                have_next_next = 1'b1;
            end
        end

        // An empty FIFO at this sample makes the current byte the last one.
        if (prefetch_slot && !fifo_empty && !have_next_reg) begin
            read_en_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (start && !fifo_empty) begin
                    state_next     = PREAMBLE;
                    busy_next      = 1'b1;
                    read_en_next   = 1'b1;
                    tx_next        = PREAMBLE_BITS[11];
                    half_cnt_next  = '0;
                    sym_idx_next   = 4'd0;
                    bit_idx_next   = 3'd7;
                    phase_next     = 1'b0;
                    have_next_next = 1'b0;
                end
            end

            PREAMBLE: begin
                if (half_end) begin
                    if (sym_idx_reg == PREAMBLE_LAST) begin
                        // First half of the first data bit inverts the line.
                        state_next   = DATA;
                        bit_idx_next = 3'd7;
                        phase_next   = 1'b0;
                        tx_next      = ~tx_reg;
                    end else begin
                        sym_idx_next = sym_idx_reg + 4'd1;
                        tx_next      = PREAMBLE_BITS[4'd10 - sym_idx_reg];
                    end
                end
            end

            DATA: begin
                if (half_end) begin
                    if (!phase_reg) begin
                        // Mid-bit transition only for a 0.
                        phase_next = 1'b1;
                        tx_next    = cur_bit ? tx_reg : ~tx_reg;
                    end else begin
                        // Every bit boundary inverts the line.
                        phase_next = 1'b0;
                        tx_next    = ~tx_reg;
                        if (bit_idx_reg != 3'd0) begin
                            bit_idx_next = bit_idx_reg - 3'd1;
                        end else if (have_next_reg) begin
                            data_next      = next_byte_reg;
                            have_next_next = 1'b0;
                            bit_idx_next   = 3'd7;
                        end else begin
                            state_next = DUMMY;
                        end
                    end
                end
            end

            DUMMY: begin
                if (half_end) begin
                    if (!phase_reg) begin
                        // Dummy 1: second half repeats the first.
                        phase_next = 1'b1;
                    end else begin
                        state_next     = IDLE;
                        phase_next     = 1'b0;
                        sym_idx_next   = 4'd0;
                        bit_idx_next   = 3'd0;
                        have_next_next = 1'b0;
                        tx_next        = 1'b0;
                        busy_next      = 1'b0;
                        done_next      = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            half_cnt_reg  <= '0;
            sym_idx_reg   <= 4'd0;
            bit_idx_reg   <= 3'd0;
            phase_reg     <= 1'b0;
            data_reg      <= 8'd0;
            next_byte_reg <= 8'd0;
            have_next_reg <= 1'b0;
            read_en_reg   <= 1'b0;
            tx_reg        <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            half_cnt_reg  <= half_cnt_next;
            sym_idx_reg   <= sym_idx_next;
            bit_idx_reg   <= bit_idx_next;
            phase_reg     <= phase_next;
            data_reg      <= data_next;
            next_byte_reg <= next_byte_next;
            have_next_reg <= have_next_next;
            read_en_reg   <= read_en_next;
            tx_reg        <= tx_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign fifo_read_en = read_en_reg;
    assign tx_out       = tx_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;

endmodule

// File: tb/tb_fifo_fm0_tx_encoder.sv
// Directed bench for fifo_fm0_tx_encoder: two instances (half period 2 and 4)
// each fed by a small show-ahead FIFO model.
module tb_fifo_fm0_tx_encoder;

    localparam int NI  = 2;
    localparam int HP0 = 2;
    localparam int HP1 = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       start        [NI];
    logic       fifo_empty   [NI];
    logic [7:0] fifo_data    [NI];
    logic       fifo_read_en [NI];
    logic       tx_out       [NI];
    logic       busy         [NI];
    logic       done         [NI];

    logic [7:0] fmem [NI][16];
    int         wr_ptr    [NI];
    int         rd_ptr    [NI] = '{default: 0};
    int         pop_count [NI] = '{default: 0};
    int         bad_pop   [NI] = '{default: 0};

    int         checks   = 0;
    int         failures = 0;

    logic       tx_log [0:2047];

    always #5 clock = ~clock;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            assign fifo_empty[gi] = (rd_ptr[gi] == wr_ptr[gi]);
            assign fifo_data[gi]  = fmem[gi][rd_ptr[gi][3:0]];

            fifo_fm0_tx_encoder #(
                .HALF_PERIOD((gi == 0) ? HP0 : HP1)
            ) u_dut (
                .clock        (clock),
                .reset        (reset),
                .start        (start[gi]),
                .fifo_empty   (fifo_empty[gi]),
                .fifo_data    (fifo_data[gi]),
                .fifo_read_en (fifo_read_en[gi]),
                .tx_out       (tx_out[gi]),
                .busy         (busy[gi]),
                .done         (done[gi])
            );
        end
    endgenerate

    // FIFO model: a pop advances the read pointer; a pop on empty is noted.
    always @(posedge clock) begin
        for (int i = 0; i < NI; i++) begin
            if (fifo_read_en[i]) begin
                pop_count[i] <= pop_count[i] + 1;
                if (rd_ptr[i] == wr_ptr[i]) bad_pop[i] <= bad_pop[i] + 1;
                else                        rd_ptr[i]  <= rd_ptr[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b);
        fmem[i][wr_ptr[i][3:0]] = b;
        wr_ptr[i] = wr_ptr[i] + 1;
    endtask

    // Starts a frame at the current negedge and follows it to the done pulse.
    // Bytes are left-aligned in payload (first byte in [23:16]).
    task automatic run_frame(input int i, input int hp, input int nb, input logic [23:0] payload,
                             input int busy_start_at, input int late_push_at,
                             input logic [7:0] late_byte, input string tag);
        int         len;
        int         busy_cnt;
        int         npop;
        int         done_at;
        int         ncap;
        int         pop_at [0:7];
        logic       eh [0:63];
        logic [11:0] pre;
        logic       last;
        logic       a;
        logic       bitv;
        int         k;
        int         wave_err;
        int         bound_err;
        logic [31:0] dec;
        logic       h0, h1, h2;
        int         want_pop;

        len      = (14 + 16 * nb) * hp;
        busy_cnt = 0;
        npop     = 0;
        done_at  = -1;
        ncap     = 0;

        // Expected half-bit levels from the FM0 rules.
        pre = 12'b110100100011;
        for (int j = 0; j < 12; j++) eh[j] = pre[11 - j];
        last = eh[11];
        k    = 12;
        for (int b = 0; b < nb * 8; b++) begin
            bitv      = payload[23 - b];
            a         = ~last;
            eh[k]     = a;
            eh[k + 1] = bitv ? a : ~a;
            last      = eh[k + 1];
            k         = k + 2;
        end
        eh[k]     = ~last;
        eh[k + 1] = ~last;
        k         = k + 2;

        start[i] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start[i] = 1'b0;
        for (int c = 0; c < len + 8 * hp; c++) begin
            if (c == busy_start_at)          start[i] = 1'b1;
            else if (c == busy_start_at + 1) start[i] = 1'b0;
            if (c == late_push_at) push(i, late_byte);
            tx_log[c] = tx_out[i];
            ncap = c + 1;
            if (busy[i]) busy_cnt++;
            if (fifo_read_en[i]) begin
                if (npop < 8) pop_at[npop] = c;
                npop++;
            end
            if (done[i]) begin
                done_at = c;
                break;
            end
            @(negedge clock);
        end
        start[i] = 1'b0;

        check({tag, "_done_at"}, done_at, len);
        check({tag, "_busy_cycles"}, busy_cnt, len);
        check({tag, "_pops"}, npop, nb);
        check({tag, "_tx_after"}, tx_out[i], 1'b0);
        for (int p = 0; p < nb && p < npop && p < 8; p++) begin
            want_pop = (p == 0) ? 0 : (12 * hp + 16 * hp * (p - 1) + 14 * hp + 1);
            check($sformatf("%s_pop%0d_cycle", tag, p), pop_at[p], want_pop);
        end

        wave_err = 0;
        for (int kk = 0; kk < k; kk++) begin
            for (int j = 0; j < hp; j++) begin
                if (kk * hp + j < ncap && kk * hp + j < len) begin
                    if (tx_log[kk * hp + j] !== eh[kk]) wave_err++;
                end
            end
        end
        check({tag, "_wave_errs"}, wave_err, 0);

        // Independent FM0 decode of the captured line.
        dec       = '0;
        bound_err = 0;
        for (int b = 0; b < nb * 8; b++) begin
            h0 = tx_log[(11 + 2 * b) * hp];
            h1 = tx_log[(12 + 2 * b) * hp];
            h2 = tx_log[(13 + 2 * b) * hp];
            if (h1 === h0) bound_err++;
            dec = {dec[30:0], (h1 === h2)};
        end
        check({tag, "_fm0_boundaries"}, bound_err, 0);
        check({tag, "_decoded"}, dec, 32'(payload >> (24 - 8 * nb)));
    endtask

    initial begin
        int          p0;
        int          hi_cnt;
        logic [29:0] got30;

        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start[i]  = 1'b0;
            wr_ptr[i] = 0;
        end
        repeat (3) @(negedge clock);

        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst%0d_tx", i), tx_out[i], 1'b0);
            check($sformatf("rst%0d_busy", i), busy[i], 1'b0);
            check($sformatf("rst%0d_rd_en", i), fifo_read_en[i], 1'b0);
            check($sformatf("rst%0d_done", i), done[i], 1'b0);
        end
        reset = 1'b0;
        @(negedge clock);

        // Reset pulse while idle.
        #2 reset = 1'b1;
        #1;
        check("idle_rst_tx", tx_out[0], 1'b0);
        check("idle_rst_busy", busy[0], 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Single byte A5 at half period 2.
        push(0, 8'hA5);
        run_frame(0, HP0, 1, 24'hA50000, -1, -1, 8'h00, "a5");
        got30 = '0;
        for (int kk = 0; kk < 30; kk++) got30 = {got30[28:0], tx_log[kk * HP0]};
        check("a5_halves", got30, 30'b110100100011_00101101_01001011_00);
        @(negedge clock);
        check("a5_done_one_cycle", done[0], 1'b0);
        check("a5_busy_low", busy[0], 1'b0);

        // Start with the FIFO empty is ignored.
        p0       = pop_count[0];
        hi_cnt   = 0;
        start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (busy[0] || done[0] || fifo_read_en[0] || tx_out[0]) hi_cnt++;
            @(negedge clock);
        end
        check("empty_start_activity", hi_cnt, 0);
        check("empty_start_pops", pop_count[0] - p0, 0);

        // Reset in the middle of DATA at half period 4.
        push(1, 8'h81);
        start[1] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start[1] = 1'b0;
        repeat (70) @(negedge clock);
        check("mid_busy_before_rst", busy[1], 1'b1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_tx", tx_out[1], 1'b0);
        check("mid_rst_busy", busy[1], 1'b0);
        check("mid_rst_rd_en", fifo_read_en[1], 1'b0);
        check("mid_rst_done", done[1], 1'b0);
        @(negedge clock);
        reset = 1'b0;
        push(1, 8'hFF);
        p0     = pop_count[1];
        hi_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (busy[1] || fifo_read_en[1] || done[1]) hi_cnt++;
        end
        check("post_rst_activity", hi_cnt, 0);
        check("post_rst_pops", pop_count[1] - p0, 0);

        // Three bytes FF 00 3C, with a start pulse while busy.
        push(1, 8'h00);
        push(1, 8'h3C);
        run_frame(1, HP1, 3, 24'hFF003C, 20, -1, 8'h00, "three");
        repeat (3) @(negedge clock);

        // FIFO empty at the bit-0 sample, byte written one cycle later;
        // then a back-to-back start in the done cycle sends the late byte.
        push(1, 8'h96);
        run_frame(1, HP1, 1, 24'h960000, -1, 26 * HP1 + 1, 8'h69, "late");
        check("b2b_in_done_cycle", done[1], 1'b1);
        run_frame(1, HP1, 1, 24'h690000, -1, -1, 8'h00, "b2b");

        @(negedge clock);
        check("bad_pops_0", bad_pop[0], 0);
        check("bad_pops_1", bad_pop[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
